hbus_mi_arb: RTL and testbench
==============================

HBUS_MI_ARB -- requirements
Module: hbus_mi_arb

Interface
Parameters: none; two requester ports, 32-bit data, 7-bit length.
REQ-001 The block SHALL have these ports, in this order:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- p0_addr_cs / p1_addr_cs  in  2  requester chip select
- p0_addr / p1_addr  in  32  requester address
- p0_len / p1_len  in  7  burst length minus one, in words
- p0_rw / p1_rw  in  1  direction (1 = read)
- p0_linear / p1_linear  in  1  linear burst
- p0_valid / p1_valid  in  1  command request
- p0_ready / p1_ready  out  1  command accepted
- p0_wdata / p1_wdata  in  32  write data
- p0_wmsk / p1_wmsk  in  4  write mask
- p0_wack / p1_wack  out  1  write word consumed
- p0_wlast / p1_wlast  out  1  last write word
- p0_rdata / p1_rdata  out  32  read data
- p0_rstb / p1_rstb  out  1  read word strobe
- p0_rlast / p1_rlast  out  1  last read word
- mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear, mi_valid  out  2/32/7/1/1/1  command to hbus_memctrl
- mi_ready  in  1  controller command accept
- mi_wdata, mi_wmsk  out  32/4  write data to controller
- mi_wack, mi_wlast  in  1/1  write handshake from controller
- mi_rdata, mi_rstb, mi_rlast  in  32/1/1  read data from controller

Function
REQ-002 The block SHALL have a three-state FSM: IDLE, CMD, DATA.
REQ-003 In IDLE with any pX_valid, the block SHALL register grant g and enter CMD on the next edge; mi_valid SHALL rise exactly 1 cycle after the first sampled pX_valid.
REQ-004 When both requesters are valid in IDLE, the grant SHALL go to the port not granted last, i.e. round-robin.
REQ-005 In CMD the block SHALL assert mi_valid=1, drive the mi_ command fields combinationally from port g, and route mi_ready to pg_ready only.
REQ-006 Requesters SHALL hold valid and the command fields stable until ready; the block SHALL NOT check this.
REQ-007 On mi_ready in CMD, the block SHALL latch pg_rw into dir and enter DATA.
REQ-008 In DATA with dir=0 (write), mi_wdata/mi_wmsk SHALL equal pg_wdata/pg_wmsk, and mi_wack/mi_wlast SHALL be routed to pg_wack/pg_wlast.
REQ-009 The write burst SHALL end on the cycle with mi_wack&mi_wlast, and the FSM SHALL return to IDLE.
REQ-010 In DATA with dir=1 (read), mi_rstb/mi_rlast SHALL be routed to pg_rstb/pg_rlast; mi_rdata SHALL be broadcast to both pX_rdata at all times.
REQ-011 The read burst SHALL end on mi_rstb&mi_rlast, and the FSM SHALL return to IDLE.
REQ-012 If an end-of-burst condition coincides with mi_ready in CMD, the FSM SHALL go directly to IDLE.
REQ-013 A new grant SHALL NOT occur before IDLE, giving a minimum of 1 idle cycle between bursts.
REQ-014 Outside IDLE, the block SHALL drive mi_valid=0 and mi_wdata/mi_wmsk=0 except as stated above.
REQ-015 Non-granted ports SHALL see ready/wack/wlast/rstb/rlast = 0.
REQ-016 mi_wack, mi_rstb and mi_ready arriving in IDLE SHALL be ignored, with no output pulse.
REQ-017 Deasserting pg_valid in CMD is a protocol violation; mi_valid SHALL remain asserted until mi_ready.

Reset
REQ-018 On rst=1 at a clk edge, the FSM SHALL go to IDLE, dir=0, and the last-grant pointer=1, so p0 wins the first contention.
REQ-019 After reset, all outputs SHALL be 0 except pX_rdata (= mi_rdata).
REQ-020 Reset mid-burst SHALL abort arbitration immediately, and the controller SHALL be reset by the same rst.

Configuration
REQ-021 With HBUS_MI_ARB_FIXED_PRIO_EN defined, p0 SHALL always win contention in IDLE and the last-grant pointer SHALL be unused; undefined (default), round-robin per REQ-004 applies.

Verification
REQ-022 p0 write addr 0x2000, len 31, alone -> mi_valid 1 cycle after p0_valid, mi_addr=0x2000, 32 p0_wack pulses, p0_wlast on 32nd, p1 outputs all 0.
REQ-023 p0 write and p1 read (addr 0x3000, len 15) valid in the same cycle after reset -> p0 served first, then p1, with exactly 16 p1_rstb and p1_rlast on 16th.
REQ-024 Both ports continuously valid for 4 bursts -> grant order p0,p1,p0,p1 (default); p0,p0,p0,p0 with HBUS_MI_ARB_FIXED_PRIO_EN.
REQ-025 rst asserted during DATA of a p1 read -> next cycle FSM in IDLE, p1_rstb=0, and p0 wins the next contention.
REQ-026 mi_ready held low 10 cycles in CMD -> mi_valid and fields stable for 10 cycles, no pX_ready until mi_ready.
REQ-027 Spurious mi_rstb in IDLE -> no pX_rstb pulse.

Source files
------------

// File: rtl/hbus_mi_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hbus_mi_arb                                                     |
// | Purpose  : Two-port burst arbiter in front of hbus_memctrl. Round-robin by |
// |            default; define HBUS_MI_ARB_FIXED_PRIO_EN to give p0 priority.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hbus_mi_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  p0_addr_cs,
    input  logic [1:0]  p1_addr_cs,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [6:0]  p0_len,
    input  logic [6:0]  p1_len,
    input  logic        p0_rw,
    input  logic        p1_rw,
    input  logic        p0_linear,
    input  logic        p1_linear,
    input  logic        p0_valid,
    input  logic        p1_valid,
    output logic        p0_ready,
    output logic        p1_ready,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p0_wmsk,
    input  logic [3:0]  p1_wmsk,
    output logic        p0_wack,
    output logic        p1_wack,
    output logic        p0_wlast,
    output logic        p1_wlast,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_rstb,
    output logic        p1_rstb,
    output logic        p0_rlast,
    output logic        p1_rlast,
    output logic [1:0]  mi_addr_cs,
    output logic [31:0] mi_addr,
    output logic [6:0]  mi_len,
    output logic        mi_rw,
    output logic        mi_linear,
    output logic        mi_valid,
    input  logic        mi_ready,
    output logic [31:0] mi_wdata,
    output logic [3:0]  mi_wmsk,
    input  logic        mi_wack,
    input  logic        mi_wlast,
    input  logic [31:0] mi_rdata,
    input  logic        mi_rstb,
    input  logic        mi_rlast
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMD  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    logic [1:0] r_state;
    logic       r_grant;
    logic       r_dir;
    logic       r_mi_valid;
    logic       w_pick;
    logic       w_g_rw;
    logic       w_wr_end;
    logic       w_rd_end;
    logic       w_cmd;
    logic       w_wr_data;
    logic       w_rd_data;

`ifdef HBUS_MI_ARB_FIXED_PRIO_EN
    assign w_pick = ~p0_valid;
`else
    logic r_last_grant;
    // Under contention the port not served last wins; otherwise the only requester.
    assign w_pick = (p0_valid & p1_valid) ? ~r_last_grant : ~p0_valid;
`endif

    assign w_g_rw   = r_grant ? p1_rw : p0_rw;
    assign w_wr_end = mi_wack & mi_wlast;
    assign w_rd_end = mi_rstb & mi_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= 1'b0;
            r_dir      <= 1'b0;
            r_mi_valid <= 1'b0;
`ifndef HBUS_MI_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (p0_valid | p1_valid) begin
                        r_grant    <= w_pick;
                        r_mi_valid <= 1'b1;
                        r_state    <= c_ST_CMD;
`ifndef HBUS_MI_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_pick;
`endif
                    end
                end
                c_ST_CMD: begin
                    if (mi_ready) begin
                        r_mi_valid <= 1'b0;
                        r_dir      <= w_g_rw;
                        // A burst that completes alongside command acceptance skips DATA.
                        r_state    <= (w_g_rw ? w_rd_end : w_wr_end) ? c_ST_IDLE : c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (r_dir ? w_rd_end : w_wr_end)
                        r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_cmd     = (r_state == c_ST_CMD);
    assign w_wr_data = (r_state == c_ST_DATA) & ~r_dir;
    assign w_rd_data = (r_state == c_ST_DATA) &  r_dir;

    assign mi_valid   = r_mi_valid;
    assign mi_addr_cs = w_cmd ? (r_grant ? p1_addr_cs : p0_addr_cs) : 2'b00;
    assign mi_addr    = w_cmd ? (r_grant ? p1_addr    : p0_addr)    : 32'd0;
    assign mi_len     = w_cmd ? (r_grant ? p1_len     : p0_len)     : 7'd0;
    assign mi_rw      = w_cmd & w_g_rw;
    assign mi_linear  = w_cmd & (r_grant ? p1_linear : p0_linear);

    assign mi_wdata = w_wr_data ? (r_grant ? p1_wdata : p0_wdata) : 32'd0;
    assign mi_wmsk  = w_wr_data ? (r_grant ? p1_wmsk  : p0_wmsk)  : 4'd0;

    assign p0_ready = w_cmd & ~r_grant & mi_ready;
    assign p1_ready = w_cmd &  r_grant & mi_ready;
    assign p0_wack  = w_wr_data & ~r_grant & mi_wack;
    assign p1_wack  = w_wr_data &  r_grant & mi_wack;
    assign p0_wlast = w_wr_data & ~r_grant & mi_wlast;
    assign p1_wlast = w_wr_data &  r_grant & mi_wlast;
    assign p0_rstb  = w_rd_data & ~r_grant & mi_rstb;
    assign p1_rstb  = w_rd_data &  r_grant & mi_rstb;
    assign p0_rlast = w_rd_data & ~r_grant & mi_rlast;
    assign p1_rlast = w_rd_data &  r_grant & mi_rlast;

    assign p0_rdata = mi_rdata;
    assign p1_rdata = mi_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hbus_mi_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hbus_mi_arb                                                  |
// | Purpose  : Randomized self-checking bench with a grant-order model and a   |
// |            behavioural memory-controller responder.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hbus_mi_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd_cs    [2];
    logic [31:0] cmd_addr  [2];
    logic [6:0]  cmd_len   [2];
    logic        cmd_rw    [2];
    logic        cmd_lin   [2];
    logic        cmd_valid [2];
    logic [31:0] wd        [2];
    logic [3:0]  wm        [2];

    logic        p0_ready, p1_ready, p0_wack, p1_wack, p0_wlast, p1_wlast;
    logic        p0_rstb, p1_rstb, p0_rlast, p1_rlast;
    logic [31:0] p0_rdata, p1_rdata;
    logic [1:0]  mi_addr_cs;
    logic [31:0] mi_addr;
    logic [6:0]  mi_len;
    logic        mi_rw, mi_linear, mi_valid;
    logic        mi_ready = 1'b0;
    logic [31:0] mi_wdata;
    logic [3:0]  mi_wmsk;
    logic        mi_wack = 1'b0, mi_wlast = 1'b0;
    logic [31:0] mi_rdata = 32'd0;
    logic        mi_rstb = 1'b0, mi_rlast = 1'b0;

    logic [1:0] rdy_v, wack_v, wlast_v, rstb_v, rlast_v;
    assign rdy_v   = {p1_ready, p0_ready};
    assign wack_v  = {p1_wack,  p0_wack};
    assign wlast_v = {p1_wlast, p0_wlast};
    assign rstb_v  = {p1_rstb,  p0_rstb};
    assign rlast_v = {p1_rlast, p0_rlast};

    int n_cmp = 0;
    int n_bad = 0;
    int last_port = 1;

    always #5 clk = ~clk;

    hbus_mi_arb dut (
        .clk(clk), .rst(rst),
        .p0_addr_cs(cmd_cs[0]), .p1_addr_cs(cmd_cs[1]),
        .p0_addr(cmd_addr[0]), .p1_addr(cmd_addr[1]),
        .p0_len(cmd_len[0]), .p1_len(cmd_len[1]),
        .p0_rw(cmd_rw[0]), .p1_rw(cmd_rw[1]),
        .p0_linear(cmd_lin[0]), .p1_linear(cmd_lin[1]),
        .p0_valid(cmd_valid[0]), .p1_valid(cmd_valid[1]),
        .p0_ready(p0_ready), .p1_ready(p1_ready),
        .p0_wdata(wd[0]), .p1_wdata(wd[1]),
        .p0_wmsk(wm[0]), .p1_wmsk(wm[1]),
        .p0_wack(p0_wack), .p1_wack(p1_wack),
        .p0_wlast(p0_wlast), .p1_wlast(p1_wlast),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_rstb(p0_rstb), .p1_rstb(p1_rstb),
        .p0_rlast(p0_rlast), .p1_rlast(p1_rlast),
        .mi_addr_cs(mi_addr_cs), .mi_addr(mi_addr), .mi_len(mi_len),
        .mi_rw(mi_rw), .mi_linear(mi_linear), .mi_valid(mi_valid),
        .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wmsk(mi_wmsk),
        .mi_wack(mi_wack), .mi_wlast(mi_wlast),
        .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    // Who should win given which ports are requesting, from the arbitration rules.
    function automatic int predict(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef HBUS_MI_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_port;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic rand_cmd(input int p, input int len_max);
        cmd_cs[p]   = 2'($urandom_range(0, 3));
        cmd_addr[p] = $urandom;
        cmd_len[p]  = 7'($urandom_range(0, len_max));
        cmd_rw[p]   = 1'($urandom_range(0, 1));
        cmd_lin[p]  = 1'($urandom_range(0, 1));
        wd[p]       = $urandom;
        wm[p]       = 4'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0;
        for (int p = 0; p < 2; p++) begin
            cmd_valid[p] = 1'b0;
            rand_cmd(p, 7);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_port = 1;
        #1;
    endtask

    // Plays the memory controller for one burst expected to belong to port p.
    task automatic serve_burst(input int p, input int stall, input bit keep);
        int t, n, cnt, gap;
        logic [1:0] oh, lastv;
        logic rd;
        logic [44:0] fld;
        oh = 2'b01 << p;
        t = 0;
        while (mi_valid !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (mi_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL burst_start: mi_valid=%b required 1 (port %0d)", mi_valid, p);
            return;
        end
        fld = {cmd_cs[p], cmd_addr[p], cmd_len[p], cmd_rw[p], cmd_lin[p]};
        n_cmp++;
        if ({mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear} !== fld) begin
            n_bad++;
            $display("FAIL cmd_fields: got %h required %h (port %0d)",
                     {mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear}, fld, p);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (mi_valid !== 1'b1 || rdy_v !== 2'b00 ||
                {mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear} !== fld) begin
                n_bad++;
                $display("FAIL cmd_stall: valid=%b ready=%b fields=%h required 1/00/%h",
                         mi_valid, rdy_v, {mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear}, fld);
            end
        end
        @(negedge clk);
        mi_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy_v !== oh) begin
            n_bad++;
            $display("FAIL ready_route: got %b required %b", rdy_v, oh);
        end
        @(negedge clk);
        mi_ready = 1'b0;
        if (!keep) cmd_valid[p] = 1'b0;
        last_port = p;
        rd  = cmd_rw[p];
        n   = int'(cmd_len[p]) + 1;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                #1;
                n_cmp++;
                if ({rdy_v, wack_v, wlast_v, rstb_v, rlast_v} !== 10'd0) begin
                    n_bad++;
                    $display("FAIL gap_quiet: pulses=%b required 0", {rdy_v, wack_v, wlast_v, rstb_v, rlast_v});
                end
                @(negedge clk);
            end
            lastv = (i == n - 1) ? oh : 2'b00;
            mi_rdata = $urandom;
            if (rd) begin
                mi_rstb = 1'b1; mi_rlast = (i == n - 1);
            end else begin
                mi_wack = 1'b1; mi_wlast = (i == n - 1);
                wd[p] = $urandom; wm[p] = 4'($urandom);
            end
            #1;
            n_cmp++;
            if (rd) begin
                if (rstb_v !== oh || rlast_v !== lastv || wack_v !== 2'b00 || mi_wdata !== 32'd0 ||
                    p0_rdata !== mi_rdata || p1_rdata !== mi_rdata) begin
                    n_bad++;
                    $display("FAIL read_beat %0d: rstb=%b rlast=%b wack=%b wdata=%h rdata=%h/%h required %b/%b/00/0/%h",
                             i, rstb_v, rlast_v, wack_v, mi_wdata, p0_rdata, p1_rdata, oh, lastv, mi_rdata);
                end
                if (rstb_v[p] === 1'b1) cnt++;
            end else begin
                if (wack_v !== oh || wlast_v !== lastv || rstb_v !== 2'b00 ||
                    mi_wdata !== wd[p] || mi_wmsk !== wm[p]) begin
                    n_bad++;
                    $display("FAIL write_beat %0d: wack=%b wlast=%b rstb=%b wdata=%h wmsk=%h required %b/%b/00/%h/%h",
                             i, wack_v, wlast_v, rstb_v, mi_wdata, mi_wmsk, oh, lastv, wd[p], wm[p]);
                end
                if (wack_v[p] === 1'b1) cnt++;
            end
            @(negedge clk);
            mi_wack = 1'b0; mi_wlast = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0;
        end
        #1;
        n_cmp++;
        if (cnt != n) begin
            n_bad++;
            $display("FAIL beat_count: got %0d required %0d", cnt, n);
        end
        n_cmp++;
        if (mi_valid !== 1'b0 || {rdy_v, wack_v, rstb_v} !== 6'd0 || mi_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL post_burst_idle: valid=%b pulses=%b wdata=%h required 0",
                     mi_valid, {rdy_v, wack_v, rstb_v}, mi_wdata);
        end
    endtask

    task automatic test_reset();
        do_reset();
        mi_rdata = $urandom;
        #1;
        n_cmp++;
        if ({mi_valid, mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear, mi_wdata, mi_wmsk} !== 80'd0 ||
            {rdy_v, wack_v, wlast_v, rstb_v, rlast_v} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: mi=%h ports=%b required 0",
                     {mi_valid, mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear, mi_wdata, mi_wmsk},
                     {rdy_v, wack_v, wlast_v, rstb_v, rlast_v});
        end
        n_cmp++;
        if (p0_rdata !== mi_rdata || p1_rdata !== mi_rdata) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h/%h required %h", p0_rdata, p1_rdata, mi_rdata);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        cmd_addr[0] = 32'h2000; cmd_len[0] = 7'd31; cmd_rw[0] = 1'b0;
        cmd_valid[0] = 1'b1;
        n_cmp++;
        if (mi_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL valid_latency_early: mi_valid=%b required 0", mi_valid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (mi_valid !== 1'b1 || mi_addr !== 32'h2000) begin
            n_bad++;
            $display("FAIL valid_latency: mi_valid=%b addr=%h required 1/00002000", mi_valid, mi_addr);
        end
        serve_burst(0, 0, 1'b0);
    endtask

    task automatic test_two_ports();
        do_reset();
        rand_cmd(0, 7); cmd_rw[0] = 1'b0;
        cmd_addr[1] = 32'h3000; cmd_len[1] = 7'd15; cmd_rw[1] = 1'b1;
        cmd_valid[0] = 1'b1; cmd_valid[1] = 1'b1;
        serve_burst(predict(cmd_valid[0], cmd_valid[1]), 1, 1'b0);
        serve_burst(predict(cmd_valid[0], cmd_valid[1]), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        rand_cmd(0, 5); rand_cmd(1, 5);
        cmd_valid[0] = 1'b1; cmd_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++)
            serve_burst(predict(1'b1, 1'b1), $urandom_range(0, 3), 1'b1);
        cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++;
        if (mi_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: mi_valid=%b required 0", mi_valid);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        rand_cmd(1, 15); cmd_rw[1] = 1'b1; cmd_valid[1] = 1'b1;
        t = 0;
        while (mi_valid !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        @(negedge clk); mi_ready = 1'b1;
        @(negedge clk); mi_ready = 1'b0; cmd_valid[1] = 1'b0;
        mi_rstb = 1'b1; mi_rlast = 1'b0; mi_rdata = $urandom;
        #1;
        n_cmp++;
        if (rstb_v !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_pre: rstb=%b required 10", rstb_v);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (rstb_v !== 2'b00 || mi_valid !== 1'b0 || rdy_v !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_abort: rstb=%b valid=%b ready=%b required 00/0/00", rstb_v, mi_valid, rdy_v);
        end
        rst = 1'b0; mi_rstb = 1'b0;
        last_port = 1;
        rand_cmd(0, 5); rand_cmd(1, 5);
        cmd_valid[0] = 1'b1; cmd_valid[1] = 1'b1;
        serve_burst(predict(cmd_valid[0], cmd_valid[1]), 0, 1'b0);
        serve_burst(predict(cmd_valid[0], cmd_valid[1]), 0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        rand_cmd(1, 3); cmd_valid[1] = 1'b1;
        serve_burst(1, 10, 1'b0);
    endtask

    task automatic test_spurious();
        do_reset();
        @(negedge clk);
        mi_rstb = 1'b1; mi_rlast = 1'b1; mi_wack = 1'b1; mi_wlast = 1'b1; mi_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rdy_v, wack_v, wlast_v, rstb_v, rlast_v} !== 10'd0) begin
            n_bad++;
            $display("FAIL spurious_idle: pulses=%b required 0", {rdy_v, wack_v, wlast_v, rstb_v, rlast_v});
        end
        @(negedge clk);
        mi_rstb = 1'b0; mi_rlast = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; mi_ready = 1'b0;
        #1;
        n_cmp++;
        if (mi_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL spurious_state: mi_valid=%b required 0", mi_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 24; k++) begin
            for (int p = 0; p < 2; p++)
                if (!cmd_valid[p] && $urandom_range(0, 1) == 1) begin
                    rand_cmd(p, 7); cmd_valid[p] = 1'b1;
                end
            if (!cmd_valid[0] && !cmd_valid[1]) begin
                rand_cmd(k % 2, 7); cmd_valid[k % 2] = 1'b1;
            end
            serve_burst(predict(cmd_valid[0], cmd_valid[1]), $urandom_range(0, 3), 1'b0);
        end
        while (cmd_valid[0] || cmd_valid[1])
            serve_burst(predict(cmd_valid[0], cmd_valid[1]), 0, 1'b0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            cmd_valid[p] = 1'b0;
            rand_cmd(p, 7);
        end
        test_reset();
        test_single_write();
        test_two_ports();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        test_spurious();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
